fir_tap_bram_arbiter: RTL and testbench

//  Shares the single-port FIR tap-coefficient BRAM between two requesters:
//  - the FIR engine (coefficient fetch during computation)
//  - the AXI-Lite configuration path (coefficient program/readback)

---
 rtl/fir_tap_bram_arbiter_if.sv | 25 ++
 rtl/fir_tap_bram_arbiter.sv | 125 ++++++++++++
 tb/tb_fir_tap_bram_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/fir_tap_bram_arbiter_if.sv
// Requester-side bus for the FIR tap-coefficient BRAM arbiter.
// One instance per requester (engine, configuration path). The requester
// uses the master modport; the arbiter uses the slave modport.
interface fir_tap_bram_arbiter_if #(
  parameter int pADDR_WIDTH = 32,
  parameter int pDATA_WIDTH = 32
);
  logic                   req;
  logic                   we;
  logic [pADDR_WIDTH-1:0] addr;
  logic [pDATA_WIDTH-1:0] wdata;
  logic                   gnt;
  logic                   rvalid;
  logic [pDATA_WIDTH-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/fir_tap_bram_arbiter.sv
// Single-port tap-coefficient BRAM arbiter between the FIR engine and the
// configuration path. Engine has fixed priority; a starvation guard forces a
// cfg win after STARVE_LIMIT consecutive denied eligible cycles. Cfg writes
// are fenced while eng_lock is high.
// Optional feature: define ARB_STATS_EN to add the arb_conflicts counter port.
module fir_tap_bram_arbiter #(
  parameter int pADDR_WIDTH  = 32,
  parameter int pDATA_WIDTH  = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   eng_lock,
  fir_tap_bram_arbiter_if.slave  eng,
  fir_tap_bram_arbiter_if.slave  cfg,
  output logic                   bram_EN,
  output logic [3:0]             bram_WE,
  output logic [pADDR_WIDTH-1:0] bram_A,
  output logic [pDATA_WIDTH-1:0] bram_Di,
  input  logic [pDATA_WIDTH-1:0] bram_Do
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]            arb_conflicts
`endif
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  typedef enum logic {S_NORM, S_FORCE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_ENG, OWN_CFG} owner_t;

  state_t           state_q;
  logic [CNT_W-1:0] starve_cnt_q;
  owner_t           rd_owner_q;

  logic cfg_elig;
  logic eng_gnt_d;
  logic cfg_gnt_d;

  // A cfg write is not a candidate while the engine holds the lock.
  assign cfg_elig = cfg.req & ~(cfg.we & eng_lock);

  // Same-cycle grant decision; nothing is granted while in reset.
  always_comb begin
    eng_gnt_d = 1'b0;
    cfg_gnt_d = 1'b0;
    if (!axis_rst) begin
      if (state_q == S_FORCE && cfg_elig) begin
        cfg_gnt_d = 1'b1;
      end else if (eng.req) begin
        eng_gnt_d = 1'b1;
      end else if (cfg_elig) begin
        cfg_gnt_d = 1'b1;
      end
    end
  end

  assign eng.gnt = eng_gnt_d;
  assign cfg.gnt = cfg_gnt_d;

  // BRAM port carries the granted access, zeroed when idle.
  assign bram_EN = eng_gnt_d | cfg_gnt_d;
  assign bram_WE = {4{(eng_gnt_d & eng.we) | (cfg_gnt_d & cfg.we)}};
  assign bram_A  = eng_gnt_d ? eng.addr  : (cfg_gnt_d ? cfg.addr  : '0);
  assign bram_Di = eng_gnt_d ? eng.wdata : (cfg_gnt_d ? cfg.wdata : '0);

  // Arbitration state, starvation counter and read-return owner.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state_q      <= S_NORM;
      starve_cnt_q <= '0;
      rd_owner_q   <= OWN_NONE;
    end else begin
      case (state_q)
        S_NORM: begin
          if (cfg_elig && !cfg_gnt_d) begin
            starve_cnt_q <= starve_cnt_q + ONE_C;
            if ((starve_cnt_q + ONE_C) == LIMIT_C) begin
              state_q <= S_FORCE;
            end
          end else begin
            starve_cnt_q <= '0;
          end
        end
        default: begin
          // Either cfg just won or it was not competing; both end the episode.
          starve_cnt_q <= '0;
          state_q      <= S_NORM;
        end
      endcase

      if (eng_gnt_d && !eng.we) begin
        rd_owner_q <= OWN_ENG;
      end else if (cfg_gnt_d && !cfg.we) begin
        rd_owner_q <= OWN_CFG;
      end else begin
        rd_owner_q <= OWN_NONE;
      end
    end
  end

  // Read return is gated by reset so a pending read is dropped immediately.
  assign eng.rvalid = (rd_owner_q == OWN_ENG) & ~axis_rst;
  assign cfg.rvalid = (rd_owner_q == OWN_CFG) & ~axis_rst;
  assign eng.rdata  = eng.rvalid ? bram_Do : '0;
  assign cfg.rdata  = cfg.rvalid ? bram_Do : '0;

`ifdef ARB_STATS_EN
  logic [15:0] conflicts_q;

  // Saturating count of cycles where both requesters ask at once.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      conflicts_q <= '0;
    end else if (eng.req && cfg.req && conflicts_q != 16'hFFFF) begin
      conflicts_q <= conflicts_q + 16'd1;
    end
  end

  assign arb_conflicts = conflicts_q;
`endif

endmodule

// File: tb/tb_fir_tap_bram_arbiter.sv
// Directed testbench for fir_tap_bram_arbiter (STARVE_LIMIT=4).
// Inputs change 1ns after each rising edge; outputs are checked 1ns later,
// so each "window" shows the grant for the current inputs and the read
// return for the previous window's grant.
module tb_fir_tap_bram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        eng_lock;
  logic        bram_EN;
  logic [3:0]  bram_WE;
  logic [31:0] bram_A;
  logic [31:0] bram_Di;
  logic [31:0] bram_Do = 32'h0;
`ifdef ARB_STATS_EN
  logic [15:0] arb_conflicts;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fir_tap_bram_arbiter_if #(.pADDR_WIDTH(32), .pDATA_WIDTH(32)) eng_if ();
  fir_tap_bram_arbiter_if #(.pADDR_WIDTH(32), .pDATA_WIDTH(32)) cfg_if ();

  fir_tap_bram_arbiter #(
    .pADDR_WIDTH (32),
    .pDATA_WIDTH (32),
    .STARVE_LIMIT(4)
  ) dut (
    .axis_clk (clk),
    .axis_rst (rst),
    .eng_lock (eng_lock),
    .eng      (eng_if.slave),
    .cfg      (cfg_if.slave),
    .bram_EN  (bram_EN),
    .bram_WE  (bram_WE),
    .bram_A   (bram_A),
    .bram_Di  (bram_Di),
    .bram_Do  (bram_Do)
`ifdef ARB_STATS_EN
    ,
    .arb_conflicts(arb_conflicts)
`endif
  );

  always #5 clk = ~clk;

  // BRAM model: a read of address A returns {16'hC0DE, A[15:0]} one cycle later.
  always @(posedge clk) begin
    if (bram_EN && bram_WE == 4'h0) begin
      bram_Do <= {16'hC0DE, bram_A[15:0]};
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance to the next window (just after the rising edge).
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_eng(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    eng_if.req = req; eng_if.we = we; eng_if.addr = addr; eng_if.wdata = wd;
  endtask

  task automatic set_cfg(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    cfg_if.req = req; cfg_if.we = we; cfg_if.addr = addr; cfg_if.wdata = wd;
  endtask

  initial begin
    // 1. Reset with every request asserted.
    rst = 1'b1;
    eng_lock = 1'b0;
    set_eng(1'b1, 1'b0, 32'h08, 32'h0);
    set_cfg(1'b1, 1'b1, 32'h0C, 32'h7);
    for (int i = 0; i < 2; i++) begin
      cyc();
      #1;
      check_eq("rst_eng_gnt",    {31'b0, eng_if.gnt},    32'h0);
      check_eq("rst_cfg_gnt",    {31'b0, cfg_if.gnt},    32'h0);
      check_eq("rst_eng_rvalid", {31'b0, eng_if.rvalid}, 32'h0);
      check_eq("rst_cfg_rvalid", {31'b0, cfg_if.rvalid}, 32'h0);
      check_eq("rst_bram_EN",    {31'b0, bram_EN},       32'h0);
      check_eq("rst_bram_WE",    {28'b0, bram_WE},       32'h0);
      check_eq("rst_bram_A",     bram_A,                 32'h0);
`ifdef ARB_STATS_EN
      check_eq("rst_conflicts",  {16'b0, arb_conflicts}, 32'h0);
`endif
    end
    cyc();
    rst = 1'b0;
    set_eng(1'b0, 1'b0, 32'h0, 32'h0);
    set_cfg(1'b0, 1'b0, 32'h0, 32'h0);

    // 2. Engine read of 0x08.
    cyc();
    set_eng(1'b1, 1'b0, 32'h08, 32'h0);
    #1;
    check_eq("rd_eng_gnt", {31'b0, eng_if.gnt}, 32'h1);
    check_eq("rd_bram_EN", {31'b0, bram_EN},    32'h1);
    check_eq("rd_bram_A",  bram_A,              32'h08);
    check_eq("rd_bram_WE", {28'b0, bram_WE},    32'h0);
    cyc();
    set_eng(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check_eq("rd_eng_rvalid", {31'b0, eng_if.rvalid}, 32'h1);
    check_eq("rd_eng_rdata",  eng_if.rdata,           32'hC0DE0008);
    check_eq("rd_cfg_rvalid", {31'b0, cfg_if.rvalid}, 32'h0);
    check_eq("rd_cfg_rdata",  cfg_if.rdata,           32'h0);
    cyc();
    #1;
    check_eq("rd_eng_rvalid_off", {31'b0, eng_if.rvalid}, 32'h0);

    // 3. Starvation: both read continuously; cfg wins in cycles 4 and 9.
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (i == 0) begin
        set_eng(1'b1, 1'b0, 32'h10, 32'h0);
        set_cfg(1'b1, 1'b0, 32'h14, 32'h0);
      end
      #1;
      check_eq($sformatf("starve_gnt_c%0d", i), {30'b0, eng_if.gnt, cfg_if.gnt},
               (i == 4 || i == 9) ? 32'h1 : 32'h2);
      if (i == 1) check_eq("starve_eng_rdata", eng_if.rdata, 32'hC0DE0010);
      if (i == 5) begin
        check_eq("starve_cfg_rvalid", {31'b0, cfg_if.rvalid}, 32'h1);
        check_eq("starve_cfg_rdata",  cfg_if.rdata,           32'hC0DE0014);
        check_eq("starve_eng_rvalid", {31'b0, eng_if.rvalid}, 32'h0);
      end
    end
    cyc();
    set_eng(1'b0, 1'b0, 32'h0, 32'h0);
    set_cfg(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
`ifdef ARB_STATS_EN
    check_eq("starve_conflicts", {16'b0, arb_conflicts}, 32'd10);
`endif

    // 4. Write fence under eng_lock.
    for (int i = 0; i < 3; i++) begin
      cyc();
      eng_lock = 1'b1;
      set_cfg(1'b1, 1'b1, 32'h40, 32'h5);
      #1;
      check_eq($sformatf("fence_blocked_c%0d", i), {31'b0, cfg_if.gnt}, 32'h0);
    end
    cyc();
    eng_lock = 1'b0;
    #1;
    check_eq("fence_cfg_gnt", {31'b0, cfg_if.gnt}, 32'h1);
    check_eq("fence_bram_WE", {28'b0, bram_WE},    32'hF);
    check_eq("fence_bram_Di", bram_Di,             32'h5);
    check_eq("fence_bram_A",  bram_A,              32'h40);
    cyc();
    eng_lock = 1'b1;
    set_cfg(1'b1, 1'b0, 32'h44, 32'h0);
    #1;
    check_eq("fence_wr_no_rvalid", {31'b0, cfg_if.rvalid}, 32'h0);
    check_eq("fence_rd_gnt",       {31'b0, cfg_if.gnt},    32'h1);
    cyc();
    eng_lock = 1'b0;
    set_cfg(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check_eq("fence_rd_rvalid", {31'b0, cfg_if.rvalid}, 32'h1);
    check_eq("fence_rd_rdata",  cfg_if.rdata,           32'hC0DE0044);

    // 5. Interleaved reads: eng 0x00, cfg 0x04, eng 0x08.
    cyc();
    set_eng(1'b1, 1'b0, 32'h00, 32'h0);
    #1;
    check_eq("il_gnt0", {30'b0, eng_if.gnt, cfg_if.gnt}, 32'h2);
    cyc();
    set_eng(1'b0, 1'b0, 32'h0, 32'h0);
    set_cfg(1'b1, 1'b0, 32'h04, 32'h0);
    #1;
    check_eq("il_gnt1",      {30'b0, eng_if.gnt, cfg_if.gnt},       32'h1);
    check_eq("il_rvalid1",   {30'b0, eng_if.rvalid, cfg_if.rvalid}, 32'h2);
    check_eq("il_eng_rdata", eng_if.rdata,                          32'hC0DE0000);
    cyc();
    set_cfg(1'b0, 1'b0, 32'h0, 32'h0);
    set_eng(1'b1, 1'b0, 32'h08, 32'h0);
    #1;
    check_eq("il_gnt2",        {30'b0, eng_if.gnt, cfg_if.gnt},       32'h2);
    check_eq("il_rvalid2",     {30'b0, eng_if.rvalid, cfg_if.rvalid}, 32'h1);
    check_eq("il_cfg_rdata",   cfg_if.rdata,                          32'hC0DE0004);
    check_eq("il_eng_rdata_0", eng_if.rdata,                          32'h0);
    cyc();
    set_eng(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check_eq("il_rvalid3",    {30'b0, eng_if.rvalid, cfg_if.rvalid}, 32'h2);
    check_eq("il_eng_rdata2", eng_if.rdata,                          32'hC0DE0008);

    // 6. Reset the cycle after an engine read grant.
    cyc();
    set_eng(1'b1, 1'b0, 32'h0C, 32'h0);
    #1;
    check_eq("rmr_gnt", {31'b0, eng_if.gnt}, 32'h1);
    cyc();
    rst = 1'b1;
    set_eng(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check_eq("rmr_rvalid_in_rst", {31'b0, eng_if.rvalid}, 32'h0);
    cyc();
    rst = 1'b0;
    #1;
    check_eq("rmr_rvalid_after", {31'b0, eng_if.rvalid}, 32'h0);
    check_eq("rmr_rdata_after",  eng_if.rdata,           32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
